// File: rtl/data_structs.sv
// ---------------------------------------------------------------------------
// data_structs
// Shared geometry types for the ray / box datapath. The sweep controller uses:
//   vec2, vec3, bbox    - packed 24-bit signed coordinate records
//   vec3_default        - value of a latched ray after reset
//   range_default       - "empty" range reported when nothing was hit
//   INFINITY_24 / NEGATIVE_INFINITY_24 - 24-bit range sentinels
//   sweep_state_e       - bbox_sweep_ctrl sequencer states
//   range_nearer()      - nearest-entry comparison used by the reduction
// ---------------------------------------------------------------------------
package data_structs;

    localparam logic signed [23:0] INFINITY_24          = 24'sh7FFFFF;
    localparam logic signed [23:0] NEGATIVE_INFINITY_24 = 24'sh800000;

    typedef struct packed {
        logic signed [23:0] x;
        logic signed [23:0] y;
    } vec2;

    typedef struct packed {
        logic signed [23:0] x;
        logic signed [23:0] y;
        logic signed [23:0] z;
    } vec3;

    typedef struct packed {
        vec3 bmin;
        vec3 bmax;
    } bbox;

    localparam vec3 vec3_default  = '0;
    // Entry at +inf and exit at -inf: an empty interval.
    localparam vec2 range_default = '{x: INFINITY_24, y: NEGATIVE_INFINITY_24};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    // Strictly nearer entry point; equal entries keep the incumbent so the
    // lowest index wins when results arrive in index order.
    function automatic logic range_nearer(input vec2 cand, input vec2 best);
        return $signed(cand.x) < $signed(best.x);
    endfunction

endpackage

// File: rtl/isect_tag_pipe.sv
// ---------------------------------------------------------------------------
// isect_tag_pipe
// Fixed-depth shift register carrying {valid, tag} alongside a datapath of
// equal latency, so the tag pops out in the same cycle as the result it
// belongs to.
// Ports:
//   i_clk    clock
//   i_clr    synchronous clear, active-high (empties every stage)
//   i_vld    valid bit entering stage 0
//   i_tag    tag entering stage 0
//   o_vld    valid bit leaving the last stage
//   o_tag    tag leaving the last stage
// ---------------------------------------------------------------------------
module isect_tag_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_tag,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_tag
);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_tag [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_tag[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/bbox_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// bbox_sweep_ctrl
// Sweeps one ray across NUM_BOXES boxes through a shared intersect unit, one
// box per cycle, and reports the nearest hit (smallest entry distance,
// lowest index on ties).
// Ports:
//   sysclk, rst_n            clock, synchronous active-low reset
//   ray_valid/ray_ready      ray handshake; ray_orig, inv_ray_dir payload
//   box_rd_en/box_rd_idx     box-table read; box_rd_data returns next cycle
//   isect_valid, isect_*     intersect unit issue stream
//   isect_hit, isect_range   intersect result, ISECT_LAT cycles after issue
//   result_valid/ready       result handshake
//   result_hit/idx/range     nearest hit (or range_default when none)
// ---------------------------------------------------------------------------
module bbox_sweep_ctrl
    import data_structs::*;
#(
    parameter int NUM_BOXES = 16,
    parameter int IDX_W     = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1,
    parameter int ISECT_LAT = 4
) (
    input  logic             sysclk,
    input  logic             rst_n,

    input  logic             ray_valid,
    output logic             ray_ready,
    input  vec3              ray_orig,
    input  vec3              inv_ray_dir,

    output logic             box_rd_en,
    output logic [IDX_W-1:0] box_rd_idx,
    input  bbox              box_rd_data,

    output logic             isect_valid,
    output vec3              isect_ray_orig,
    output vec3              isect_inv_dir,
    output bbox              isect_box,
    output vec2              isect_prev_range,
    input  logic             isect_hit,
    input  vec2              isect_range,

    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_hit,
    output logic [IDX_W-1:0] result_idx,
    output vec2              result_range
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOXES - 1);

    sweep_state_e     r_state;
    logic [IDX_W-1:0] r_rd_cnt;
    logic             r_isect_vld;
    logic [IDX_W-1:0] r_isect_idx;
    vec3              r_ray_orig;
    vec3              r_inv_dir;
    logic             r_best_vld;
    logic [IDX_W-1:0] r_best_idx;
    vec2              r_best_range;

    logic             w_tag_clr;
    logic             w_tag_vld;
    logic [IDX_W-1:0] w_tag_idx;
    logic             w_sweeping;
    logic             w_take;
    logic             w_last_back;

    assign w_tag_clr = ~rst_n;

    // The tag pipe mirrors the intersect unit's latency; a result is only
    // trusted when a valid tag emerges with it.
    isect_tag_pipe #(
        .DEPTH (ISECT_LAT),
        .WIDTH (IDX_W)
    ) u_tag_pipe (
        .i_clk (sysclk),
        .i_clr (w_tag_clr),
        .i_vld (r_isect_vld),
        .i_tag (r_isect_idx),
        .o_vld (w_tag_vld),
        .o_tag (w_tag_idx)
    );

    assign w_sweeping  = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_take      = w_sweeping && w_tag_vld && isect_hit &&
                         (!r_best_vld || range_nearer(isect_range, r_best_range));
    // Results return in index order, so the last index leaving the pipe
    // means everything issued has been reduced.
    assign w_last_back = w_tag_vld && (w_tag_idx == LAST_IDX);

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rd_cnt     <= '0;
            r_isect_vld  <= 1'b0;
            r_isect_idx  <= '0;
            r_ray_orig   <= vec3_default;
            r_inv_dir    <= vec3_default;
            r_best_vld   <= 1'b0;
            r_best_idx   <= '0;
            r_best_range <= range_default;
        end else begin
            // Box data arrives one cycle after the read, so the issue strobe
            // and its index trail the read by one register.
            r_isect_vld <= (r_state == ISSUE);
            r_isect_idx <= r_rd_cnt;

            if (w_take) begin
                r_best_vld   <= 1'b1;
                r_best_idx   <= w_tag_idx;
                r_best_range <= isect_range;
            end

            case (r_state)
                IDLE: begin
                    if (ray_valid) begin
                        r_ray_orig   <= ray_orig;
                        r_inv_dir    <= inv_ray_dir;
                        r_best_vld   <= 1'b0;
                        r_best_idx   <= '0;
                        r_best_range <= range_default;
                        r_rd_cnt     <= '0;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_rd_cnt == LAST_IDX) begin
                        r_rd_cnt <= '0;
                        r_state  <= DRAIN;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_last_back) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ray_ready        = (r_state == IDLE);
    assign box_rd_en        = (r_state == ISSUE);
    assign box_rd_idx       = r_rd_cnt;

    assign isect_valid      = r_isect_vld;
    assign isect_ray_orig   = r_ray_orig;
    assign isect_inv_dir    = r_inv_dir;
    assign isect_box        = box_rd_data;
    assign isect_prev_range = '{x: NEGATIVE_INFINITY_24, y: INFINITY_24};

    assign result_valid     = (r_state == DONE);
    assign result_hit       = r_best_vld;
    assign result_idx       = r_best_idx;
    assign result_range     = r_best_range;

endmodule

// File: doc/bbox_sweep_ctrl.md
# bbox_sweep_ctrl

Sequencer that sweeps one ray across a table of `NUM_BOXES` axis-aligned boxes through a shared `ray_bbox_intersect` instance, one box per cycle, and reports the nearest hit. It sits between the ray source (`path_tracer_top` level) and the intersect datapath. It owns the box-table read port, the intersect-unit issue stream and the nearest-hit reduction.

## Interface
Parameters:
- `NUM_BOXES`, 16: boxes per sweep, ≥1.
- `IDX_W`, `$clog2(NUM_BOXES)` (min 1): box index width.
- `ISECT_LAT`, 4: cycles from intersect inputs presented to `isect_hit`/`isect_range` valid, ≥1.

Ports:
- Clocking and reset:
  - `sysclk`  in  1  single clock.
  - `rst_n`  in  1  reset, synchronous, active-low.
- Ray input:
  - `ray_valid`  in  1  ray offered.
  - `ray_ready`  out  1  controller idle and able to accept.
  - `ray_orig`  in  vec3  ray origin.
  - `inv_ray_dir`  in  vec3  reciprocal direction.
- Box table:
  - `box_rd_en`  out  1  box-table read strobe.
  - `box_rd_idx`  out  IDX_W  box index read.
  - `box_rd_data`  in  bbox  valid the cycle after `box_rd_en`.
- Intersect unit:
  - `isect_valid`  out  1  intersect inputs meaningful this cycle.
  - `isect_ray_orig`  out  vec3  latched origin.
  - `isect_inv_dir`  out  vec3  latched inv dir.
  - `isect_box`  out  bbox  equals `box_rd_data`.
  - `isect_prev_range`  out  vec2  constant `'{NEGATIVE_INFINITY_24, INFINITY_24}`.
  - `isect_hit`  in  1  intersect result.
  - `isect_range`  in  vec2  entry (x) / exit (y).
- Result output:
  - `result_valid`  out  1  sweep result available.
  - `result_ready`  in  1  consumer accepts.
  - `result_hit`  out  1  any box hit.
  - `result_idx`  out  IDX_W  nearest hit box.
  - `result_range`  out  vec2  range of nearest hit.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `ray_ready`=1. On `ray_valid&&ray_ready`: latch ray, clear best, `rd_cnt`←0, go to ISSUE.
  - ISSUE: `box_rd_en`=1, `box_rd_idx`=`rd_cnt`, increment each cycle. After index NUM_BOXES-1, go to DRAIN.
  - DRAIN: wait until the tag pipe is empty and the last result has been reduced, then go to DONE.
  - DONE: `result_valid`=1. On `result_ready`, go to IDLE.
- Issue: `isect_valid` = registered `box_rd_en`. The issued index enters a tag pipe of depth `ISECT_LAT` together with the valid bit.
- Reduction:
  - Applies when the tag pipe output is valid and `isect_hit`=1.
  - If no best yet, or `isect_range.x` < best.x (signed, strict), update best = {idx, range}.
  - Results return in index order, so ties resolve to the lowest index.
- No hit: `result_hit`=0, `result_idx`=0, `result_range`=`range_default`.
- `result_*` are stable while `result_valid`=1 and `result_ready`=0. New rays are not accepted in this condition.
- Intersect outputs with no matching valid tag are ignored.

## Timing
- Accept in cycle A:
  - `box_rd_idx`=k at cycle A+1+k.
  - `isect_valid` at A+2+k.
  - Result k reduced at A+2+k+ISECT_LAT.
  - `result_valid` rises at A+NUM_BOXES+ISECT_LAT+2.
- Throughput: one box per cycle, no bubbles. Rays are handled one at a time, with no overlap between sweeps.
- `ray_ready` rises the cycle after the result handshake. The earliest next accept is that cycle.
- Reset (rst_n=0 at an edge), values after the edge:
  - State = IDLE.
  - `ray_ready`=1.
  - `box_rd_en`, `isect_valid`, `result_valid`, `result_hit` = 0.
  - `box_rd_idx`, `result_idx` = 0.
  - `result_range` = `range_default`.
  - Tag pipe cleared.
  - Latched ray = `vec3_default`.
- Reset mid-sweep: abort. In-flight intersect results are discarded and never update best.
- NUM_BOXES=1: ISSUE lasts one cycle. Latency is ISECT_LAT+3.

## Structure
- `data_structs` already provides vec2, vec3, bbox, `vec3_default`, `range_default`. `data_macros.sv` already provides `INFINITY_24`, `NEGATIVE_INFINITY_24` and `FF`.
- Add typedef `sweep_state_e` (IDLE/ISSUE/DRAIN/DONE) to `data_structs`.
- Sub-module `isect_tag_pipe`: parameterized depth/width shift register of {valid, idx}, synchronous clear.

## Test plan
Bench replaces the intersect unit with a scripted stub of latency ISECT_LAT. Defaults: NUM_BOXES=4, ISECT_LAT=4.
- Hits idx1 x=15 and idx3 x=5 -> `result_hit`=1, `result_idx`=3, `result_range.x`=5, `result_valid` exactly 10 cycles after accept.
- All misses -> `result_hit`=0, `result_idx`=0, `result_range`=`range_default`.
- Tie idx0 and idx2, both x=7 -> `result_idx`=0.
- Issue order -> `box_rd_idx` 0,1,2,3 on consecutive cycles; 4 contiguous `isect_valid` pulses; `isect_prev_range` constant.
- `result_ready` low 10 cycles with `ray_valid` held high -> outputs stable, `ray_ready`=0; accept occurs the cycle after the handshake.
- rst_n low at A+3 -> outputs at reset values next cycle. The next ray with one hit at idx2 x=9 -> `result_idx`=2, unaffected by stale stub outputs.
